// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared definitions for the ULA scheduler: op-code width,
//               op-code constants and the scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    // Width of the per-requester operation code
    localparam int c_OP_W = 3;

    // Operation codes
    localparam logic [c_OP_W-1:0] c_OP_ADD = 3'd0;
    localparam logic [c_OP_W-1:0] c_OP_SUB = 3'd1;
    localparam logic [c_OP_W-1:0] c_OP_MUL = 3'd2;
    localparam logic [c_OP_W-1:0] c_OP_DIV = 3'd3;
    localparam logic [c_OP_W-1:0] c_OP_AND = 3'd4;
    localparam logic [c_OP_W-1:0] c_OP_OR  = 3'd5;
    localparam logic [c_OP_W-1:0] c_OP_XOR = 3'd6;
    localparam logic [c_OP_W-1:0] c_OP_NOR = 3'd7;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the multi-cycle operations
    function automatic logic is_muldiv(input logic [c_OP_W-1:0] op);
        return (op == c_OP_MUL) || (op == c_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_core.sv
`default_nettype none
// ============================================================================
// Module      : ula_core
// Description : Purely combinational arithmetic/logic datapath.
//               Operands are unsigned and zero-extended to 2*DW bits.
// Ports       : op_i     - operation code
//               a_i, b_i - DW-bit operands
//               result_o - 2*DW-bit result
//               dz_o     - divide-by-zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module ula_core
    import ula_pkg::*;
#(
    parameter int DW = 3
) (
    input  logic [c_OP_W-1:0] op_i,
    input  logic [DW-1:0]     a_i,
    input  logic [DW-1:0]     b_i,
    output logic [2*DW-1:0]   result_o,
    output logic              dz_o
);

    logic [2*DW-1:0] za_w;
    logic [2*DW-1:0] zb_w;

    assign za_w = {{DW{1'b0}}, a_i};
    assign zb_w = {{DW{1'b0}}, b_i};

    always_comb begin
        result_o = '0;
        dz_o     = 1'b0;
        case (op_i)
            c_OP_ADD: result_o = za_w + zb_w;
            c_OP_SUB: result_o = za_w - zb_w;
            c_OP_MUL: result_o = za_w * zb_w;
            c_OP_DIV: begin
                if (b_i == '0) begin
                    result_o = '1;
                    dz_o     = 1'b1;
                end else begin
                    result_o = za_w / zb_w;
                end
            end
            // Logic ops are evaluated on DW bits, so NOR never sets upper bits
            c_OP_AND: result_o = {{DW{1'b0}}, a_i & b_i};
            c_OP_OR:  result_o = {{DW{1'b0}}, a_i | b_i};
            c_OP_XOR: result_o = {{DW{1'b0}}, a_i ^ b_i};
            c_OP_NOR: result_o = {{DW{1'b0}}, ~(a_i | b_i)};
            default:  result_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ula_sched.sv
`default_nettype none
// ============================================================================
// Module      : ula_sched
// Description : Two-port round-robin scheduler in front of a shared ALU.
//               IDLE arbitrates and captures the winner's op/operands,
//               EXEC counts the operation latency, DONE presents the result.
// Ports       : CLOCK_27          - clock
//               RST_N             - asynchronous active-low reset
//               req_i[1:0]        - level requests, one per port
//               op0_i/op1_i       - op codes per port
//               a0_i/b0_i/a1_i/b1_i - operands per port
//               gnt_o[1:0]        - one-hot grant pulse (operands captured)
//               done_o[1:0]       - one-hot completion pulse
//               result_o          - last result, held until next completion
//               dz_o              - divide-by-zero flag of last result
//               busy_o            - high whenever not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module ula_sched
    import ula_pkg::*;
#(
    parameter int DW         = 3,
    parameter int MULDIV_LAT = 2
) (
    input  logic              CLOCK_27,
    input  logic              RST_N,
    input  logic [1:0]        req_i,
    input  logic [c_OP_W-1:0] op0_i,
    input  logic [c_OP_W-1:0] op1_i,
    input  logic [DW-1:0]     a0_i,
    input  logic [DW-1:0]     b0_i,
    input  logic [DW-1:0]     a1_i,
    input  logic [DW-1:0]     b1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [2*DW-1:0]   result_o,
    output logic              dz_o,
    output logic              busy_o
);

    localparam logic [2:0] c_LAT = 3'(MULDIV_LAT);

    state_t            state_q;
    logic              owner_q;
    logic              prio_q;     // index of the port that wins a tie
    logic [c_OP_W-1:0] op_q;
    logic [DW-1:0]     a_q;
    logic [DW-1:0]     b_q;
    logic [2:0]        cnt_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic [2*DW-1:0]   result_q;
    logic              dz_q;

    logic              winner_d;
    logic [c_OP_W-1:0] op_d;
    logic [2:0]        len_d;
    logic [2*DW-1:0]   core_res_w;
    logic              core_dz_w;

    // A lone request always wins; on a tie the pointer decides
    assign winner_d = (req_i == 2'b11) ? prio_q : req_i[1];
    assign op_d     = winner_d ? op1_i : op0_i;
    assign len_d    = is_muldiv(op_d) ? c_LAT : 3'd1;

    ula_core #(
        .DW (DW)
    ) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (core_res_w),
        .dz_o     (core_dz_w)
    );

    // The counter is loaded with the EXEC length and the state leaves EXEC
    // one edge after it reaches zero, so done_o rises exactly
    // (EXEC length + 1) edges after the grant edge.
    always_ff @(posedge CLOCK_27 or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        owner_q <= winner_d;
                        prio_q  <= ~winner_d;
                        gnt_q   <= winner_d ? 2'b10 : 2'b01;
                        op_q    <= op_d;
                        a_q     <= winner_d ? a1_i : a0_i;
                        b_q     <= winner_d ? b1_i : b0_i;
                        cnt_q   <= len_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 3'd0) begin
                        result_q <= core_res_w;
                        dz_q     <= core_dz_w;
                        done_q   <= owner_q ? 2'b10 : 2'b01;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    // No arbitration here: requesters are still dropping req_i
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign dz_o     = dz_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ula_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_sched
// Description : Directed self-checking bench for ula_sched (DW=3,
//               MULDIV_LAT=2). Inputs are driven and outputs sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_sched;

    localparam int DW  = 3;
    localparam int LAT = 2;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req;
    logic [2:0]      op0, op1;
    logic [DW-1:0]   a0, b0, a1, b1;
    logic [1:0]      gnt, done;
    logic [2*DW-1:0] result;
    logic            dz, busy;

    int n_checks = 0;
    int n_fail   = 0;

    ula_sched #(
        .DW         (DW),
        .MULDIV_LAT (LAT)
    ) dut (
        .CLOCK_27 (clk),
        .RST_N    (rst_n),
        .req_i    (req),
        .op0_i    (op0),
        .op1_i    (op1),
        .a0_i     (a0),
        .b0_i     (b0),
        .a1_i     (a1),
        .b1_i     (b1),
        .gnt_o    (gnt),
        .done_o   (done),
        .result_o (result),
        .dz_o     (dz),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: raise one port's request, record the grant seen one
    // edge later, count edges from grant to done, drop req in the DONE cycle
    // and step into the following IDLE cycle. lat=99 means done never came.
    task automatic issue(input int port, input logic [2:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [1:0] gnt_seen, output int lat,
                         output logic [1:0] done_seen);
        if (port == 0) begin op0 = op; a0 = a; b0 = b; end
        else           begin op1 = op; a1 = a; b1 = b; end
        req[port] = 1'b1;
        @(negedge clk);
        gnt_seen  = gnt;
        done_seen = 2'b00;
        lat       = 99;
        // Operands must be ignored after the grant edge
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; op0 = ~op0; op1 = ~op1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                done_seen = done;
                lat       = i;
                break;
            end
        end
        req[port] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, done, result, dz, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b done=%b res=%0d dz=%b busy=%b, want all 0",
                     gnt, done, result, dz, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_add();
        logic [1:0] g, d; int lat;
        issue(0, 3'd0, 3'd5, 3'd3, g, lat, d);
        n_checks++;
        if (g !== 2'b01) begin n_fail++; $display("FAIL add_gnt: got %b want 01", g); end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_checks++;
        if (d !== 2'b01) begin n_fail++; $display("FAIL add_done: got %b want 01", d); end
        n_checks++;
        if (result !== 6'd8 || dz !== 1'b0) begin
            n_fail++; $display("FAIL add_result: got %0d dz=%b want 8 dz=0", result, dz);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 2'b00) begin
            n_fail++; $display("FAIL add_back_idle: got busy=%b done=%b want 0 00", busy, done);
        end
    endtask

    task automatic test_sub();
        logic [1:0] g, d; int lat;
        issue(1, 3'd1, 3'd2, 3'd5, g, lat, d);
        n_checks++;
        if (g !== 2'b10) begin n_fail++; $display("FAIL sub_gnt: got %b want 10", g); end
        n_checks++;
        if (d !== 2'b10 || lat !== 2) begin
            n_fail++; $display("FAIL sub_done: got %b lat=%0d want 10 lat=2", d, lat);
        end
        n_checks++;
        if (result !== 6'd61 || dz !== 1'b0) begin
            n_fail++; $display("FAIL sub_result: got %0d dz=%b want 61 dz=0", result, dz);
        end
    endtask

    task automatic test_div();
        logic [1:0] g, d; int lat;
        issue(0, 3'd3, 3'd6, 3'd0, g, lat, d);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL div0_latency: got %0d want 3", lat); end
        n_checks++;
        if (result !== 6'd63 || dz !== 1'b1) begin
            n_fail++; $display("FAIL div0_result: got %0d dz=%b want 63 dz=1", result, dz);
        end
        issue(0, 3'd3, 3'd7, 3'd2, g, lat, d);
        n_checks++;
        if (result !== 6'd3 || dz !== 1'b0 || lat !== 3) begin
            n_fail++; $display("FAIL div_result: got %0d dz=%b lat=%0d want 3 dz=0 lat=3",
                               result, dz, lat);
        end
    endtask

    task automatic test_ops();
        // op, a, b, expected result, expected latency
        logic [2:0] t_op [7] = '{3'd7, 3'd7, 3'd4, 3'd5, 3'd6, 3'd2, 3'd0};
        logic [2:0] t_a  [7] = '{3'd5, 3'd0, 3'd6, 3'd4, 3'd5, 3'd5, 3'd7};
        logic [2:0] t_b  [7] = '{3'd2, 3'd0, 3'd3, 3'd1, 3'd3, 3'd6, 3'd7};
        logic [5:0] t_r  [7] = '{6'd0, 6'd7, 6'd2, 6'd5, 6'd6, 6'd30, 6'd14};
        int         t_l  [7] = '{2, 2, 2, 2, 2, 3, 2};
        logic [1:0] g, d; int lat;
        for (int k = 0; k < 7; k++) begin
            issue(k % 2, t_op[k], t_a[k], t_b[k], g, lat, d);
            n_checks++;
            if (result !== t_r[k] || dz !== 1'b0 || lat !== t_l[k]) begin
                n_fail++;
                $display("FAIL op_table[%0d] op=%0d: got res=%0d dz=%b lat=%0d want res=%0d dz=0 lat=%0d",
                         k, t_op[k], result, dz, lat, t_r[k], t_l[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        bit         seen;
        // Fresh reset so port 0 holds the tie priority
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op0 = 3'd0; a0 = 3'd1; b0 = 3'd1;
        op1 = 3'd0; a1 = 3'd1; b1 = 3'd1;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp  = (g % 2 == 0) ? 2'b01 : 2'b10;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (gnt != 2'b00) seen = 1'b1;
            end
            n_checks++;
            if (gnt !== exp) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", g, gnt, exp);
            end
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (done != 2'b00) seen = 1'b1;
            end
            n_checks++;
            if (done !== exp) begin
                n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", g, done, exp);
            end
            req = req & ~exp;
            @(negedge clk);
            req = 2'b11;
        end
        req = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] g, d; int lat;
        bit         spurious;
        op0 = 3'd2; a0 = 3'd7; b0 = 3'd7;
        req = 2'b01;
        @(negedge clk);
        n_checks++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_mul_gnt: got %b want 01", gnt); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, done, result, dz, busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_exec: got gnt=%b done=%b res=%0d dz=%b busy=%b, want all 0",
                     gnt, done, result, dz, busy);
        end
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done != 2'b00) spurious = 1'b1;
        end
        rst_n = 1'b1;
        // Request is still held; it must be re-arbitrated and completed
        issue(0, 3'd2, 3'd7, 3'd7, g, lat, d);
        n_checks++;
        if (spurious !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got done during reset"); end
        n_checks++;
        if (g !== 2'b01 || d !== 2'b01 || lat !== 3) begin
            n_fail++; $display("FAIL rst_regrant: got gnt=%b done=%b lat=%0d want 01 01 3", g, d, lat);
        end
        n_checks++;
        if (result !== 6'd49 || dz !== 1'b0) begin
            n_fail++; $display("FAIL rst_mul_result: got %0d dz=%b want 49 dz=0", result, dz);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_div();
        test_ops();
        test_back_to_back();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ula_sched.md
ULA_SCHED -- requirements
Module: ula_sched

Interface
REQ-001 Parameter DW, default 3, operand width in bits.
REQ-002 Parameter MULDIV_LAT, default 2, EXEC cycles for MUL/DIV (range 1..7).
REQ-003 CLOCK_27  input  1  sole clock, all state on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  2  per-requester request, level, held until done.
REQ-006 op0_i, op1_i  input  3  operation code per requester.
REQ-007 a0_i, b0_i, a1_i, b1_i  input  DW each  operands per requester.
REQ-008 gnt_o  output  2  one-hot, one-cycle pulse: operands of that port captured.
REQ-009 done_o  output  2  one-hot, one-cycle pulse: result_o valid for that port.
REQ-010 result_o  output  2*DW  last result, held until next DONE.
REQ-011 dz_o  output  1  divide-by-zero flag of last result, qualified by done_o.
REQ-012 busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-014 IDLE with any req_i high SHALL, on the next edge, latch winner's op/a/b, pulse gnt_o[winner], load the cycle counter, enter EXEC.
REQ-015 EXEC SHALL last 1 cycle for op 0,1,4,5,6,7 and MULDIV_LAT cycles for op 2,3, then enter DONE.
REQ-016 DONE SHALL last exactly 1 cycle: done_o[owner]=1, result_o/dz_o updated on entry; next state IDLE; no arbitration in DONE.
REQ-017 Latency SHALL be granting edge + EXEC length + 1 edges to done_o (ADD: done_o asserted 2 edges after grant edge).
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting, the port not granted last wins; after reset port 0 has priority.
REQ-019 Requesters SHALL drop req_i in the cycle done_o is high; req_i still high in the following IDLE cycle is a new request.
REQ-020 req_i deasserted during EXEC SHALL NOT abort the operation; done_o still pulses.
REQ-021 Operand/op inputs SHALL be ignored outside the grant edge.
REQ-022 Op encoding: 0 ADD, 1 SUB, 2 MUL, 3 DIV (unsigned quotient), 4 AND, 5 OR, 6 XOR, 7 NOR.
REQ-023 Operands unsigned, zero-extended to 2*DW; ADD, SUB, MUL results modulo 2^(2*DW); logic ops computed on DW bits then zero-extended.
REQ-024 DIV with b=0 SHALL give result_o all ones and dz_o=1; dz_o=0 for every other result.

Reset
REQ-025 RST_N low SHALL immediately force state IDLE, gnt_o=0, done_o=0, result_o=0, dz_o=0, busy_o=0, counter 0, round-robin pointer to port-0 priority.
REQ-026 Reset during EXEC or DONE SHALL discard the operation with no done_o pulse; after release the request is re-arbitrated from IDLE.

Structure
REQ-027 Package ula_pkg SHALL hold op-code constants, the state enum and the 3-bit op width.
REQ-028 Sub-module ula_core SHALL be the pure combinational datapath (op, a, b -> result, dz), instantiated once.
REQ-029 Arbiter, FSM and counter SHALL live in ula_sched.

Verification
REQ-030 Port0 ADD a=5 b=3 -> gnt_o=01 next edge; done_o=01 two edges later; result_o=8, dz_o=0.
REQ-031 Port1 SUB a=2 b=5 -> result_o=61 (6'b111101), done_o=10, dz_o=0.
REQ-032 Port0 DIV a=6 b=0, MULDIV_LAT=2 -> done_o three edges after grant; result_o=63, dz_o=1; then DIV 7/2 -> 3, dz_o=0.
REQ-033 Both req from reset, held continuously (dropped/re-raised per REQ-019) -> grants alternate 01,10,01,10.
REQ-034 RST_N low mid-EXEC of a MUL -> all outputs 0 immediately, no done_o; after release held req re-granted, MUL 7*7 -> result_o=49.
REQ-035 Port0 NOR a=5 b=2 -> result_o=0; a=0 b=0 -> result_o=7.
